ifetch_queue: RTL and testbench

Instruction-fetch front end between the pipelined MIPS core's fetch/decode boundary and the synchronous single-port instruction ROM (1-cycle read latency).
- Generates the sequential fetch PC and issues ROM reads.
- Buffers returned instructions with their PCs in a small FIFO, so ROM latency and decode stalls are decoupled.
- Flushes everything on a branch/jump redirect.

---
 rtl/ifetch_queue.sv | 110 +++++++++++
 tb/tb_ifetch_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential PC generation, 1-cycle ROM reads and a
// small instruction/PC FIFO toward decode, flushed on branch/jump redirect.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          ADDR_W   = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic              instr_valid,
   output logic [31:0]       instr,
   output logic [31:0]       instr_pc,
   input  logic              instr_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   fpc_q, fpc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];
   logic [31:0]   pcs_q  [DEPTH];
   logic [31:0]   pcs_d  [DEPTH];

   logic          push;
   logic          pop;
   logic [CW-1:0] occ;

   // Credit counts queued entries plus the response still on its way back.
   assign occ         = count_q + CW'(inflight_q);
   assign imem_en     = !rst && !redirect && (occ < CW'(DEPTH));
   assign imem_addr   = fpc_q[ADDR_W+1:2];
   assign instr_valid = (count_q != '0);
   assign instr       = data_q[rd_ptr_q];
   assign instr_pc    = pcs_q[rd_ptr_q];

   assign push = inflight_q && !redirect;
   assign pop  = instr_valid && instr_ready;

   always_comb begin
      fpc_d         = fpc_q;
      inflight_d    = imem_en;
      inflight_pc_d = inflight_pc_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      data_d        = data_q;
      pcs_d         = pcs_q;

      if (imem_en) begin
         fpc_d         = fpc_q + 32'd4;
         inflight_pc_d = fpc_q;
      end

      if (redirect) begin
         fpc_d    = redirect_pc & ~32'h0000_0003;
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (push) begin
            data_d[wr_ptr_q] = imem_data;
            pcs_d[wr_ptr_q]  = inflight_pc_q;
            wr_ptr_d         = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc_q         <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            pcs_q[i]  <= '0;
         end
      end else begin
         fpc_q         <= fpc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         data_q        <= data_d;
         pcs_q         <= pcs_d;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue; ROM model returns word k = 0x1000 + k one
// cycle after each request.
module tb_ifetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_en;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;

   int checks   = 0;
   int failures = 0;

   ifetch_queue #(.DEPTH(4), .ADDR_W(6), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_en     (imem_en),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_en) imem_data <= 32'h1000 + {26'b0, imem_addr};
   end

   // Advance to just after the next rising edge (start of a new cycle).
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at the start of cycle 0, reset just released.
   task automatic do_reset(input logic ready);
      rst         = 1'b1;
      redirect    = 1'b0;
      instr_ready = ready;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      next_cycle();
      #1;
      checks++;
      if (imem_en !== 1'b0) begin failures++; $display("FAIL reset_imem_en got=%b exp=0", imem_en); end
      checks++;
      if ({instr_valid, instr, instr_pc} !== 65'd0) begin
         failures++;
         $display("FAIL reset_outputs got valid=%b instr=%h pc=%h exp all 0", instr_valid, instr, instr_pc);
      end
   endtask

   task automatic test_stream();
      do_reset(1'b1);
      #1;
      checks++;
      if (imem_en !== 1'b1 || imem_addr !== 6'd0) begin
         failures++; $display("FAIL stream_first_issue got en=%b addr=%h exp en=1 addr=00", imem_en, imem_addr);
      end
      for (int c = 0; c < 10; c++) begin
         if (c < 2) begin
            checks++;
            if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_latency cycle=%0d got valid=%b exp 0", c, instr_valid); end
         end else begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'((c-2)*4) || instr !== 32'h1000 + 32'(c-2)) begin
               failures++;
               $display("FAIL stream_seq cycle=%0d got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                        c, instr_valid, instr_pc, instr, 32'((c-2)*4), 32'h1000 + 32'(c-2));
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_backpressure();
      int issues = 0;
      int got    = 0;
      do_reset(1'b0);
      for (int c = 0; c < 10; c++) begin
         #1;
         if (imem_en) issues++;
         next_cycle();
      end
      checks++;
      if (issues != 4) begin failures++; $display("FAIL bp_issue_count got=%0d exp=4", issues); end
      checks++;
      if (imem_en !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
         failures++; $display("FAIL bp_full_hold got en=%b v=%b pc=%h exp en=0 v=1 pc=0", imem_en, instr_valid, instr_pc);
      end
      instr_ready = 1'b1;
      #1;
      checks++;
      if (imem_en !== 1'b0) begin failures++; $display("FAIL bp_pop_credit got en=%b exp 0", imem_en); end
      for (int c = 0; c < 12 && got < 6; c++) begin
         if (instr_valid) begin
            checks++;
            if (instr_pc !== 32'(got*4)) begin
               failures++; $display("FAIL bp_drain idx=%0d got pc=%h exp pc=%h", got, instr_pc, 32'(got*4));
            end
            got++;
         end
         next_cycle();
      end
      checks++;
      if (got != 6) begin failures++; $display("FAIL bp_drain_timeout got=%0d exp=6", got); end
   endtask

   task automatic test_redirect();
      do_reset(1'b0);
      for (int c = 0; c < 4; c++) next_cycle();
      // cycle 4: three entries queued, one response in flight
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0040;
      #1;
      checks++;
      if (imem_en !== 1'b0) begin failures++; $display("FAIL redir_no_issue got en=%b exp 0", imem_en); end
      next_cycle();
      redirect = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 6'h10) begin
         failures++; $display("FAIL redir_r1 got v=%b en=%b addr=%h exp v=0 en=1 addr=10", instr_valid, imem_en, imem_addr);
      end
      next_cycle();
      checks++;
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_r2 got v=%b exp 0", instr_valid); end
      next_cycle();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h1010) begin
         failures++; $display("FAIL redir_r3 got v=%b pc=%h instr=%h exp v=1 pc=40 instr=1010", instr_valid, instr_pc, instr);
      end
      next_cycle();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h1010) begin
         failures++; $display("FAIL redir_hold got v=%b pc=%h instr=%h exp v=1 pc=40 instr=1010", instr_valid, instr_pc, instr);
      end
      instr_ready = 1'b1;
      next_cycle();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h44) begin
         failures++; $display("FAIL redir_next got v=%b pc=%h exp v=1 pc=44", instr_valid, instr_pc);
      end
   endtask

   task automatic test_redirect_pop();
      do_reset(1'b1);
      for (int c = 0; c < 5; c++) next_cycle();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0013;
      next_cycle();
      redirect = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || imem_addr !== 6'h04) begin
         failures++; $display("FAIL rpop_r1 got v=%b addr=%h exp v=0 addr=04", instr_valid, imem_addr);
      end
      next_cycle();
      checks++;
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL rpop_stale got v=%b pc=%h exp v=0", instr_valid, instr_pc); end
      next_cycle();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr !== 32'h1004) begin
         failures++; $display("FAIL rpop_r3 got v=%b pc=%h instr=%h exp v=1 pc=10 instr=1004", instr_valid, instr_pc, instr);
      end
      next_cycle();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h14) begin
         failures++; $display("FAIL rpop_r4 got v=%b pc=%h exp v=1 pc=14", instr_valid, instr_pc);
      end
   endtask

   task automatic test_async_reset();
      do_reset(1'b1);
      for (int c = 0; c < 5; c++) next_cycle();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({instr_valid, instr, instr_pc, imem_en} !== 66'd0) begin
         failures++;
         $display("FAIL areset_immediate got v=%b instr=%h pc=%h en=%b exp all 0", instr_valid, instr, instr_pc, imem_en);
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (imem_en !== 1'b1 || imem_addr !== 6'd0) begin
         failures++; $display("FAIL areset_restart got en=%b addr=%h exp en=1 addr=00", imem_en, imem_addr);
      end
      next_cycle();
      checks++;
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL areset_stale got v=%b pc=%h exp v=0", instr_valid, instr_pc); end
      next_cycle();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h1000) begin
         failures++; $display("FAIL areset_first got v=%b pc=%h instr=%h exp v=1 pc=0 instr=1000", instr_valid, instr_pc, instr);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [3];
      logic [5:0]  exp_addr [3];
      exp_pc   = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      exp_addr = '{6'h3F, 6'h00, 6'h01};
      do_reset(1'b1);
      next_cycle();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      next_cycle();
      redirect = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (c < 3) begin
            checks++;
            if (imem_en !== 1'b1 || imem_addr !== exp_addr[c]) begin
               failures++; $display("FAIL wrap_addr idx=%0d got en=%b addr=%h exp en=1 addr=%h", c, imem_en, imem_addr, exp_addr[c]);
            end
         end
         if (c >= 2) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc[c-2] || instr !== 32'h1000 + {26'b0, exp_addr[c-2]}) begin
               failures++;
               $display("FAIL wrap_pc idx=%0d got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                        c-2, instr_valid, instr_pc, instr, exp_pc[c-2], 32'h1000 + {26'b0, exp_addr[c-2]});
            end
         end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_pop();
      test_async_reset();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
